// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 unsigned multiply (MULTU) and divide (DIVU)
// with architectural HI/LO registers, one iteration per cycle, 32 cycles.
//
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   start, op       request an operation (op: 0 = MULTU, 1 = DIVU)
//   A, B            operands, latched when start is accepted
//   mthi, mtlo      write wdata to HI / LO when not busy
//   wdata           move-to data
//   hi, lo          HI/LO registers (product high/low, remainder/quotient)
//   busy            operation running (registered)
//   done            one-cycle pulse when hi/lo hold a new result (registered)
module muldiv_unit #(
    parameter logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 2 * W;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          op_q,    op_d;
    logic [W-1:0]  a_q,     a_d;
    logic [W-1:0]  b_q,     b_d;
    logic [AW-1:0] acc_q,   acc_d;
    logic [W-1:0]  hi_q,    hi_d;
    logic [W-1:0]  lo_q,    lo_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    // One iteration of either algorithm on the accumulator.
    logic [W:0]    mul_sum;
    logic [AW-1:0] mul_next;
    logic [W:0]    rem_sh;
    logic [W-1:0]  div_diff;
    logic          div_ge;
    logic [AW-1:0] div_next;
    logic [AW-1:0] acc_step;

    always_comb begin
        // Multiply: acc = {partial product high, remaining multiplier bits}.
        mul_sum  = {1'b0, acc_q[AW-1:W]} + (acc_q[0] ? {1'b0, a_q} : (W+1)'(0));
        mul_next = {mul_sum, acc_q[W-1:1]};
        // Divide: acc = {remainder, dividend bits shifting into quotient}.
        // The 33-bit compare stays correct even when the shifted remainder overflows 32 bits.
        rem_sh   = acc_q[AW-1:W-1];
        div_ge   = (rem_sh >= {1'b0, b_q});
        div_diff = rem_sh[W-1:0] - b_q;
        div_next = div_ge ? {div_diff, acc_q[W-2:0], 1'b1}
                          : {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
        acc_step = op_q ? div_next : mul_next;
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // A concurrent mthi/mtlo is dropped in favour of the new operation.
                    state_d = RUN;
                    cnt_d   = CW'(W - 1);
                    op_d    = op;
                    a_d     = A;
                    b_d     = B;
                    acc_d   = op ? {W'(0), A} : {W'(0), B};
                end else begin
                    state_d = IDLE;
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = CW'(cnt_q - CW'(1));
                if (cnt_q == CW'(0)) begin
                    state_d = DONE;
                    if (op_q && (b_q == W'(0))) begin
                        hi_d = a_q;
                        lo_d = DIV_ZERO_Q;
                    end else begin
                        hi_d = acc_step[AW-1:W];
                        lo_d = acc_step[W-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results, a
// monitor pops and checks them on every done pulse.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    muldiv_unit dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain unsigned arithmetic.
    function automatic exp_t model(input logic o, input logic [31:0] a, input logic [31:0] b, input int due);
        exp_t        e;
        logic [63:0] p;
        e.due = due;
        if (!o) begin
            p    = 64'(a) * 64'(b);
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
        end else begin
            e.hi = a % b;
            e.lo = a / b;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rstn && done) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no pending op (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("result_hi", 64'(hi), 64'(e.hi));
                check("result_lo", 64'(lo), 64'(e.lo));
                check("latency_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Issue an op at a negedge and follow it to its done pulse.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, input bit mt_same);
        exp_t e;
        int   busy_n;
        bit   seen;
        e = model(o, a, b, cyc + 33);
        sbq.push_back(e);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        if (mt_same) begin
            mtlo  = 1'b1;
            wdata = $urandom;
        end
        busy_n = 0;
        seen   = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            start = 1'b0;
            mthi  = 1'b0;
            mtlo  = 1'b0;
            A     = $urandom;
            B     = $urandom;
            if (disturb && n == 10) begin
                start = 1'b1;
                op    = 1'b0;
                A     = 32'd3;
                B     = 32'd3;
                mthi  = 1'b1;
                wdata = 32'hDEAD;
            end
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_n++;
                check("hold_hi", 64'(hi), 64'(hi_m));
                check("hold_lo", 64'(lo), 64'(lo_m));
            end
        end
        start = 1'b0;
        mthi  = 1'b0;
        check("busy_cycles", 64'(busy_n), 64'd32);
        check("done_seen", 64'(seen), 64'd1);
        hi_m = e.hi;
        lo_m = e.lo;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);
    endtask

    task automatic mt_write(input bit h, input bit l, input logic [31:0] d);
        mthi  = h;
        mtlo  = l;
        wdata = d;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        if (h) hi_m = d;
        if (l) lo_m = d;
        check("mt_hi", 64'(hi), 64'(hi_m));
        check("mt_lo", 64'(lo), 64'(lo_m));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        repeat (2) @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        run_op(1'b0, 32'd7, 32'd6, 1'b0, 1'b0);
        idle_cycle();
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(1'b1, 32'd100, 32'd7, 1'b0, 1'b0);
        run_op(1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
        idle_cycle();
        run_op(1'b1, 32'd100, 32'd7, 1'b1, 1'b0);
        idle_cycle();
        mt_write(1'b1, 1'b1, 32'h1234_5678);
        mt_write(1'b1, 1'b0, 32'hCAFE_0001);
        mt_write(1'b0, 1'b1, 32'hCAFE_0002);
        run_op(1'b0, $urandom, $urandom, 1'b0, 1'b1);
        run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        run_op(1'b1, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            logic        o;
            logic [31:0] a;
            logic [31:0] b;
            o = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op(o, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_cycle();
            if ($urandom_range(0, 2) == 0) mt_write(1'($urandom_range(0, 1)), 1'b1, $urandom);
        end

        // Abort a running multiply with reset.
        start = 1'b1;
        op    = 1'b0;
        A     = 32'd7;
        B     = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_hi", 64'(hi), 64'd0);
        check("async_rst_lo", 64'(lo), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        hi_m = '0;
        lo_m = '0;
        dn = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        check("no_activity_after_abort", 64'(dn), 64'd0);
        run_op(1'b0, 32'd2, 32'd3, 1'b0, 1'b0);
        idle_cycle();

        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
